lbmem_reader: RTL

//  Read-driven line buffer: consumer-paced counterpart of the write-driven delay-line buffer.

---
 rtl/lbmem_reader.sv | 77 +++++++
 1 files changed

// File: rtl/lbmem_reader.sv
// Read-driven line buffer: upstream pushes pixels, the consumer pulls them in order once
// THRESH entries have accumulated; once streaming, it drains to empty before re-arming.
module lbmem_reader #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned THRESH = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     wen,
  output logic                     wready,
  input  logic                     ren,
  output logic                     avail,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {StFill, StStream} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     waddr_q, raddr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  rdata_q;
  logic              rvalid_q;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wacc, racc;

  assign wready = (count_q != CW'(DEPTH));
  assign avail  = (state_q == StStream) && (count_q != '0);
  assign wacc   = wen && wready;
  assign racc   = ren && avail;
  assign count_d = count_q + CW'(wacc) - CW'(racc);

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign count  = count_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:   if (count_d >= CW'(THRESH)) state_d = StStream;
      StStream: if (count_d == '0)          state_d = StFill;
      default:  state_d = StFill;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StFill;
      waddr_q  <= '0;
      raddr_q  <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rvalid_q <= racc;
      if (wacc) waddr_q <= waddr_q + 1'b1;
      if (racc) begin
        raddr_q <= raddr_q + 1'b1;
        rdata_q <= mem[raddr_q];
      end
    end
  end

  // Storage carries no reset; contents are only observable after being written.
  always_ff @(posedge CLK) begin
    if (!RESET && wacc) mem[waddr_q] <= wdata;
  end

endmodule
